// File: rtl/sic_issue_dispatch_pkg.sv
// Shared SIC packet type, dispatch defaults and the round-robin pick helper
// used by the issue dispatcher.
package sic_issue_dispatch_pkg;

  localparam int SIC_NUM_PHY_REGS       = 32;
  localparam int SIC_NUM_ECRS           = 4;
  localparam int SIC_PREG_W             = $clog2(SIC_NUM_PHY_REGS);
  localparam int SIC_ECR_W              = $clog2(SIC_NUM_ECRS);
  localparam int SIC_ID_W_MAX           = 8;
  localparam int SIC_MAX_SICS           = 16;
  localparam int SIC_MAX_SICS_W         = 4;
  localparam int SIC_FIFO_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic                    valid;
    logic [SIC_ID_W_MAX-1:0] issue_id;
    logic [7:0]              opcode;
    logic [SIC_PREG_W-1:0]   dst;
    logic [SIC_PREG_W-1:0]   src1;
    logic [SIC_PREG_W-1:0]   src2;
    logic [SIC_ECR_W-1:0]    ecr;
    logic [15:0]             imm;
  } sic_packet_t;

  // One-hot of the first set mask bit at or after ptr, wrapping at n.
  function automatic logic [SIC_MAX_SICS-1:0] sic_rr_pick(
    input int unsigned             n,
    input logic [SIC_MAX_SICS-1:0] mask,
    input int unsigned             ptr
  );
    logic [SIC_MAX_SICS-1:0] pick;
    logic                    found;
    int unsigned             idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < SIC_MAX_SICS; k++) begin
      idx = ptr + k;
      idx = (idx >= n) ? idx - n : idx;
      if (!found && (k < n) && mask[idx[SIC_MAX_SICS_W-1:0]]) begin
        pick[idx[SIC_MAX_SICS_W-1:0]] = 1'b1;
        found = 1'b1;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sic_pkt_fifo.sv
// In-order packet buffer with push/pop/flush; head is the oldest entry.
// A push while full is ignored, flush empties the buffer and wins over push/pop.
module sic_pkt_fifo
  import sic_issue_dispatch_pkg::*;
#(
  parameter type T     = logic,
  parameter int  DEPTH = SIC_FIFO_DEPTH_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  input  logic flush,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  T [DEPTH-1:0]     mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      rd_ptr_d = do_pop ? rd_ptr_q + AW'(1'b1) : rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1'b1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1'b1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sic_issue_dispatch.sv
// Buffers decoded packets, stamps monotonic issue_ids and delivers at most one
// packet per cycle to a requesting SIC, chosen round-robin, as a one-cycle pulse.
module sic_issue_dispatch
  import sic_issue_dispatch_pkg::*;
#(
  parameter int NUM_SICS     = 4,
  parameter int NUM_PHY_REGS = SIC_NUM_PHY_REGS,
  parameter int NUM_ECRS     = SIC_NUM_ECRS,
  parameter int ID_WIDTH     = 4,
  parameter int FIFO_DEPTH   = SIC_FIFO_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  sic_packet_t                in_pkt,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic [NUM_SICS-1:0]        sic_req,
  output sic_packet_t [NUM_SICS-1:0] sic_pkt,
  output logic                       issued
);

  localparam int PTR_W = (NUM_SICS > 1) ? $clog2(NUM_SICS) : 1;

  // The packet struct is sized by the package; other register/ECR counts are not representable.
  if ((NUM_PHY_REGS != SIC_NUM_PHY_REGS) || (NUM_ECRS != SIC_NUM_ECRS) ||
      (NUM_SICS < 1) || (NUM_SICS > SIC_MAX_SICS) ||
      (ID_WIDTH < 1) || (ID_WIDTH > SIC_ID_W_MAX)) begin : g_bad_params
    $error("sic_issue_dispatch: unsupported parameter set");
  end

  logic                       fifo_full, fifo_empty;
  sic_packet_t                fifo_head, push_pkt;
  logic                       push, pop, grant_any;
  logic [ID_WIDTH-1:0]        id_cnt_q, id_cnt_d;
  logic [PTR_W-1:0]           rr_q, rr_d, grant_idx;
  logic [NUM_SICS-1:0]        pulse_mask, cand;
  logic [SIC_MAX_SICS-1:0]    cand_ext, pick_ext;
  sic_packet_t [NUM_SICS-1:0] sic_pkt_q, sic_pkt_d;
  logic                       issued_q, issued_d;

  sic_pkt_fifo #(
    .T     (sic_packet_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_pkt),
    .pop   (pop),
    .flush (flush),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign in_ready = !fifo_full;
  assign sic_pkt  = sic_pkt_q;
  assign issued   = issued_q;

  // Arbitration: SICs pulsed this cycle are masked so they never get back-to-back packets.
  always_comb begin
    for (int i = 0; i < NUM_SICS; i++) begin
      pulse_mask[i] = sic_pkt_q[i].valid;
    end
    cand                   = sic_req & ~pulse_mask;
    cand_ext               = '0;
    cand_ext[NUM_SICS-1:0] = cand;
    pick_ext               = sic_rr_pick(NUM_SICS, cand_ext, 32'(rr_q));
    grant_idx              = '0;
    for (int i = 0; i < SIC_MAX_SICS; i++) begin
      grant_idx = pick_ext[i] ? PTR_W'(i) : grant_idx;
    end
    grant_any = (|pick_ext) && !fifo_empty && !flush;
    pop       = grant_any;
    push      = in_valid && !fifo_full && !flush;
  end

  // Stamping, pointer advance and next delivery pulse.
  always_comb begin
    push_pkt          = in_pkt;
    push_pkt.valid    = 1'b1;
    push_pkt.issue_id = SIC_ID_W_MAX'(id_cnt_q);
    id_cnt_d          = push ? id_cnt_q + ID_WIDTH'(1'b1) : id_cnt_q;
    if (grant_any) begin
      rr_d = (grant_idx == PTR_W'(NUM_SICS - 1)) ? '0 : grant_idx + PTR_W'(1'b1);
    end else begin
      rr_d = rr_q;
    end
    for (int i = 0; i < NUM_SICS; i++) begin
      sic_pkt_d[i] = (grant_any && (grant_idx == PTR_W'(i))) ? fifo_head : '0;
    end
    issued_d = grant_any;
  end

  // Registered delivery outputs and dispatch state.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_cnt_q  <= '0;
      rr_q      <= '0;
      sic_pkt_q <= '0;
      issued_q  <= 1'b0;
    end else begin
      id_cnt_q  <= id_cnt_d;
      rr_q      <= rr_d;
      sic_pkt_q <= sic_pkt_d;
      issued_q  <= issued_d;
    end
  end

endmodule

// File: tb/tb_sic_issue_dispatch.sv
// Self-checking bench for sic_issue_dispatch: directed cycle table, a 2-bit-id
// wrap sequence, and randomized traffic against a queue-based reference model.
module tb_sic_issue_dispatch;
  import sic_issue_dispatch_pkg::*;

  localparam int NS    = 4;
  localparam int DEPTH = 4;
  localparam int IDW   = 4;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, flush;
  logic                 in_ready, in_ready2, issued, issued2;
  logic [NS-1:0]        sic_req;
  sic_packet_t          in_pkt;
  sic_packet_t [NS-1:0] sic_pkt, sic_pkt2;
  int                   n_tests = 0;
  int                   n_fail  = 0;

  always #5 clk = ~clk;

  sic_issue_dispatch #(.NUM_SICS(NS), .ID_WIDTH(IDW), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .in_pkt(in_pkt), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .sic_req(sic_req), .sic_pkt(sic_pkt), .issued(issued)
  );

  sic_issue_dispatch #(.NUM_SICS(NS), .ID_WIDTH(2), .FIFO_DEPTH(DEPTH)) u_dut_id2 (
    .clk(clk), .rst(rst), .in_pkt(in_pkt), .in_valid(in_valid), .in_ready(in_ready2),
    .flush(flush), .sic_req(sic_req), .sic_pkt(sic_pkt2), .issued(issued2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic sic_packet_t rand_pkt();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[$bits(sic_packet_t)-1:0];
  endfunction

  task automatic drive(input logic r, input logic f, input logic v, input logic [NS-1:0] q);
    rst      = r;
    flush    = f;
    in_valid = v;
    sic_req  = q;
    in_pkt   = rand_pkt();
  endtask

  // Directed vectors: inputs for one edge and the outputs expected just after it.
  typedef struct {
    logic          rst;
    logic          flush;
    logic          vld;
    logic [NS-1:0] req;
    logic [NS-1:0] mask;
    int            id;
    logic          rdy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic f, input logic v, input logic [NS-1:0] q,
                     input logic [NS-1:0] m, input int id, input logic rdy);
    vec_t t;
    t.rst = r; t.flush = f; t.vld = v; t.req = q; t.mask = m; t.id = id; t.rdy = rdy;
    tbl.push_back(t);
  endtask

  // Reference model state: buffered packets, next id, round-robin start, current outputs.
  sic_packet_t          mq[$];
  int                   m_id, m_rr;
  sic_packet_t [NS-1:0] m_pkt;
  logic                 m_issued;

  task automatic model_step();
    logic [NS-1:0] pulses;
    int            g, s;
    logic          was_full;
    sic_packet_t   p;
    if (rst) begin
      mq.delete();
      m_id = 0; m_rr = 0; m_pkt = '0; m_issued = 1'b0;
      return;
    end
    for (int i = 0; i < NS; i++) pulses[i] = m_pkt[i].valid;
    was_full = (mq.size() == DEPTH);
    g = -1;
    if (!flush && mq.size() > 0) begin
      for (int k = 0; k < NS; k++) begin
        s = (m_rr + k) % NS;
        if (g < 0 && sic_req[s] && !pulses[s]) g = s;
      end
    end
    m_pkt    = '0;
    m_issued = 1'b0;
    if (g >= 0) begin
      m_pkt[g] = mq.pop_front();
      m_issued = 1'b1;
      m_rr     = (g + 1) % NS;
    end
    if (flush) begin
      mq.delete();
    end else if (in_valid && !was_full) begin
      p          = in_pkt;
      p.valid    = 1'b1;
      p.issue_id = 8'(m_id);
      mq.push_back(p);
      m_id = (m_id + 1) % (1 << IDW);
    end
  endtask

  initial begin
    logic [NS-1:0] vm;
    int            q1[$];
    int            q2[$];
    int            exp2[6];

    drive(1'b0, 1'b0, 1'b0, '0);

    // Reset, back-to-back delivery to 0,1,2
    add(1,0,0,4'hF,4'b0000,0,1);
    add(0,0,1,4'hF,4'b0000,0,1);
    add(0,0,1,4'hF,4'b0001,0,1);
    add(0,0,1,4'hF,4'b0010,1,1);
    add(0,0,0,4'hF,4'b0100,2,1);
    add(0,0,0,4'hF,4'b0000,0,1);
    // Single requester: no back-to-back pulses to SIC2
    add(0,0,1,4'h4,4'b0000,0,1);
    add(0,0,1,4'h4,4'b0100,3,1);
    add(0,0,0,4'h4,4'b0000,0,1);
    add(0,0,0,4'h4,4'b0100,4,1);
    add(0,0,0,4'h0,4'b0000,0,1);
    // Fill to full with no requesters, then release via SIC1
    add(0,0,1,4'h0,4'b0000,0,1);
    add(0,0,1,4'h0,4'b0000,0,1);
    add(0,0,1,4'h0,4'b0000,0,1);
    add(0,0,1,4'h0,4'b0000,0,0);
    add(0,0,1,4'h0,4'b0000,0,0);
    add(0,0,1,4'h2,4'b0010,5,1);
    add(0,0,0,4'h0,4'b0000,0,1);
    // Flush with coincident push; counter keeps going
    add(0,1,1,4'hF,4'b0000,0,1);
    add(0,0,1,4'h0,4'b0000,0,1);
    add(0,0,0,4'hF,4'b0100,9,1);
    add(0,0,0,4'hF,4'b0000,0,1);
    // Round-robin fairness, then reset squashing an in-flight grant
    add(1,0,0,4'hF,4'b0000,0,1);
    add(0,0,1,4'hF,4'b0000,0,1);
    add(0,0,1,4'hF,4'b0001,0,1);
    add(0,0,1,4'hF,4'b0010,1,1);
    add(0,0,1,4'hF,4'b0100,2,1);
    add(0,0,1,4'hF,4'b1000,3,1);
    add(0,0,1,4'hF,4'b0001,4,1);
    add(0,0,1,4'hF,4'b0010,5,1);
    add(0,0,1,4'hF,4'b0100,6,1);
    add(0,0,1,4'hF,4'b1000,7,1);
    add(1,0,1,4'hF,4'b0000,0,1);
    add(0,0,1,4'hF,4'b0000,0,1);
    add(0,0,0,4'hF,4'b0001,0,1);
    add(0,0,0,4'hF,4'b0000,0,1);

    @(negedge clk);
    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].flush, tbl[k].vld, tbl[k].req);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NS; i++) vm[i] = sic_pkt[i].valid;
      check($sformatf("row%0d valid_mask", k), 64'(vm), 64'(tbl[k].mask));
      check($sformatf("row%0d issued", k), 64'(issued), 64'(|tbl[k].mask));
      check($sformatf("row%0d in_ready", k), 64'(in_ready), 64'(tbl[k].rdy));
      for (int i = 0; i < NS; i++) begin
        if (tbl[k].mask[i]) check($sformatf("row%0d sic%0d issue_id", k, i),
                                  64'(sic_pkt[i].issue_id), 64'(tbl[k].id));
        else check($sformatf("row%0d sic%0d zero", k, i), 64'(sic_pkt[i]), 64'(0));
      end
    end

    // Two-bit issue_id wraps 0,1,2,3,0,1 while the 4-bit instance counts 0..5
    exp2 = '{0, 1, 2, 3, 0, 1};
    drive(1'b1, 1'b0, 1'b0, 4'hF);
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 14; c++) begin
      drive(1'b0, 1'b0, c < 6, 4'hF);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (sic_pkt[i].valid)  q1.push_back(int'(sic_pkt[i].issue_id));
        if (sic_pkt2[i].valid) q2.push_back(int'(sic_pkt2[i].issue_id));
      end
    end
    check("id2 delivery_count", 64'(q2.size()), 64'(6));
    check("id4 delivery_count", 64'(q1.size()), 64'(6));
    for (int j = 0; j < 6 && j < q2.size(); j++) check($sformatf("id2 seq%0d", j), 64'(q2[j]), 64'(exp2[j]));
    for (int j = 0; j < 6 && j < q1.size(); j++) check($sformatf("id4 seq%0d", j), 64'(q1[j]), 64'(j));

    // Randomized traffic against the reference model
    drive(1'b1, 1'b0, 1'b0, '0);
    model_step();
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      check($sformatf("rnd%0d in_ready", c), 64'(in_ready), 64'(mq.size() < DEPTH));
      check($sformatf("rnd%0d issued", c), 64'(issued), 64'(m_issued));
      for (int i = 0; i < NS; i++)
        check($sformatf("rnd%0d sic%0d pkt", c, i), 64'(sic_pkt[i]), 64'(m_pkt[i]));
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 2) != 0,
            ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom));
      model_step();
      @(posedge clk);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
